main_mem_ctrl: RTL and testbench

Parametrised, handshaked block-transfer main memory that sits below the cache controller. It holds `2^DEPTH_BITS` blocks of `WORDS` words each and services one block read or block write-back per request. It has a programmable access latency and a valid/ready response channel. On reset it self-initialises every block to a known address pattern, so cache fills are checkable without preloading.

---
 rtl/main_mem_ctrl.sv | 131 +++++++++++++
 tb/tb_main_mem_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/main_mem_ctrl.sv
// Block-transfer main memory with programmable access latency and valid/ready response.
// Self-initialises every block to its own word-address pattern after reset.
module main_mem_ctrl #(
  parameter int WORD_W     = 32,
  parameter int WORDS      = 16,
  parameter int DEPTH_BITS = 6,
  parameter int ADDR_W     = 32,
  parameter int LATENCY    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [WORDS*WORD_W-1:0] req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [WORDS*WORD_W-1:0] resp_data,
  output logic                    init_done
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int BLK_W = WORDS * WORD_W;
  localparam int NBLK  = 2 ** DEPTH_BITS;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t                state;
  logic [DEPTH_BITS-1:0] init_idx;
  logic [DEPTH_BITS-1:0] blk_idx;
  logic [CNT_W-1:0]      cnt;
  logic                  wr_q;
  logic [BLK_W-1:0]      wdata_q;

  logic [BLK_W-1:0]      mem [NBLK];
  logic                  mem_we;
  logic [DEPTH_BITS-1:0] mem_widx;
  logic [BLK_W-1:0]      mem_wdata;
  logic [BLK_W-1:0]      init_block;

  // Offset and alias bits of the address are intentionally dropped.
  logic unused_addr;
  assign unused_addr = ^req_addr;

  always_comb begin
    init_block = '0;
    for (int i = 0; i < WORDS; i++) begin
      init_block[WORD_W*i +: WORD_W] = WORD_W'({init_idx, OFF_W'(i)});
    end
  end

  // Single write port shared by the init sweep and write-back commits.
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = '0;
    mem_wdata = '0;
    if (!rst) begin
      if (state == ST_INIT) begin
        mem_we    = 1'b1;
        mem_widx  = init_idx;
        mem_wdata = init_block;
      end else if (state == ST_WAIT && cnt == '0 && wr_q) begin
        mem_we    = 1'b1;
        mem_widx  = blk_idx;
        mem_wdata = wdata_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_widx] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_INIT;
      init_idx   <= '0;
      cnt        <= '0;
      blk_idx    <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      init_done  <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          init_idx <= init_idx + 1'b1;
          if (init_idx == DEPTH_BITS'(NBLK - 1)) begin
            state     <= ST_IDLE;
            init_done <= 1'b1;
            req_ready <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (req_valid) begin
            blk_idx   <= req_addr[OFF_W +: DEPTH_BITS];
            wr_q      <= req_write;
            wdata_q   <= req_wdata;
            cnt       <= CNT_W'(LATENCY - 1);
            req_ready <= 1'b0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            resp_data  <= wr_q ? wdata_q : mem[blk_idx];
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Directed bench for main_mem_ctrl: default instance plus a LATENCY=1 instance
// sharing clock, reset and request bus, selected by 'sel'.
module tb_main_mem_ctrl;

  localparam int BLK_W = 512;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic             req_write;
  logic             resp_ready;
  logic             sel;
  logic [31:0]      req_addr;
  logic [BLK_W-1:0] req_wdata;

  logic             req_ready_a, resp_valid_a, init_done_a;
  logic [BLK_W-1:0] resp_data_a;
  logic             req_ready_b, resp_valid_b, init_done_b;
  logic [BLK_W-1:0] resp_data_b;

  logic             req_ready_m, resp_valid_m, init_done_m;
  logic [BLK_W-1:0] resp_data_m;

  assign req_ready_m  = sel ? req_ready_b  : req_ready_a;
  assign resp_valid_m = sel ? resp_valid_b : resp_valid_a;
  assign init_done_m  = sel ? init_done_b  : init_done_a;
  assign resp_data_m  = sel ? resp_data_b  : resp_data_a;

  int checks = 0;
  int errors = 0;

  main_mem_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid & ~sel),
    .req_ready  (req_ready_a),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid_a),
    .resp_ready (resp_ready),
    .resp_data  (resp_data_a),
    .init_done  (init_done_a)
  );

  main_mem_ctrl #(.LATENCY(1)) dut_l1 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid & sel),
    .req_ready  (req_ready_b),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid_b),
    .resp_ready (resp_ready),
    .resp_data  (resp_data_b),
    .init_done  (init_done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  // Block whose word i equals base + i.
  function automatic logic [BLK_W-1:0] pat(input logic [31:0] base);
    logic [BLK_W-1:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[32*i +: 32] = base + 32'(i);
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [BLK_W-1:0] got,
                             input logic [BLK_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge with the DUT idle; returns at the falling
  // edge where resp_valid is first seen, lat = rising edges since accept.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                               input logic [BLK_W-1:0] wdata, output int lat);
    checkOutput("req_ready_idle", req_ready_m, 1'b1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid_m && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic readCheck(input string tag, input logic [31:0] addr,
                           input logic [BLK_W-1:0] exp, input int exp_lat);
    int lat;
    applyStimulus(1'b0, addr, '0, lat);
    checkOutput({tag, "_lat"}, lat, exp_lat);
    checkOutput({tag, "_data"}, resp_data_m, exp);
    @(negedge clk);
    checkOutput({tag, "_drop"}, resp_valid_m, 1'b0);
  endtask

  initial begin
    int lat;
    int cyc;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b1;
    sel        = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req_ready", req_ready_a, 1'b0);
    checkOutput("rst_resp_valid", resp_valid_a, 1'b0);
    checkOutput("rst_init_done", init_done_a, 1'b0);
    checkOutput("rst_resp_data", resp_data_a, '0);

    // Release reset with a stray request pending during init.
    rst       = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h35;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (k == 63) req_valid = 1'b0;
      checkOutput("init_done_edge", init_done_a, (k == 64));
      checkOutput("init_req_ready", req_ready_a, (k == 64));
      checkOutput("init_no_resp", resp_valid_a, 1'b0);
    end

    readCheck("rd35", 32'h35, pat(32'h30), 4);

    applyStimulus(1'b1, 32'h40, pat(32'hA5A50000), lat);
    checkOutput("wr40_lat", lat, 4);
    checkOutput("wr40_echo", resp_data_a, pat(32'hA5A50000));
    @(negedge clk);
    checkOutput("wr40_drop", resp_valid_a, 1'b0);
    readCheck("rd4c", 32'h4C, pat(32'hA5A50000), 4);
    readCheck("rd50", 32'h50, pat(32'h50), 4);
    readCheck("rd3f", 32'h3F, pat(32'h30), 4);

    // Backpressure with a competing write request held on the bus.
    resp_ready = 1'b0;
    applyStimulus(1'b0, 32'h20, '0, lat);
    checkOutput("bp_lat", lat, 4);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h20;
    req_wdata = '1;
    for (int j = 0; j < 3; j++) begin
      checkOutput("bp_valid", resp_valid_a, 1'b1);
      checkOutput("bp_data", resp_data_a, pat(32'h20));
      checkOutput("bp_req_ready", req_ready_a, 1'b0);
      @(negedge clk);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_valid", resp_valid_a, 1'b0);
    checkOutput("bp_release_ready", req_ready_a, 1'b1);
    readCheck("rd20_after_bp", 32'h20, pat(32'h20), 4);

    // Reset while an all-ones write is still waiting to commit.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h80;
    req_wdata = '1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_resp_valid", resp_valid_a, 1'b0);
    checkOutput("midrst_req_ready", req_ready_a, 1'b0);
    checkOutput("midrst_init_done", init_done_a, 1'b0);
    rst = 1'b0;
    cyc = 0;
    while (!init_done_a && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("reinit_cycles", cyc, 64);
    readCheck("rd80_after_rst", 32'h80, pat(32'h80), 4);
    readCheck("rd40_after_rst", 32'h40, pat(32'h40), 4);

    // LATENCY=1 instance: aliasing of high address bits.
    sel = 1'b1;
    checkOutput("l1_init_done", init_done_m, 1'b1);
    readCheck("l1_rd400", 32'h400, pat(32'h0), 1);
    readCheck("l1_rd7f5", 32'h7F5, pat(32'h3F0), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
